vec_div_stream: RTL and testbench
=================================

Name: vec_div_stream

Overview:
- Multi-lane, streaming IEEE-754 floating-point divider for the RMSnorm vector-engine path.
- Divides NUM_LANES operand pairs per transaction through a fixed-latency pipelined divide core.
- Adds what a bare fixed-latency divider lacks: valid/ready backpressure, a credit-protected output FIFO, per-transaction tag passthrough, and a reciprocal mode (1.0/b).

Parameters:
- SIG_WIDTH, 23, mantissa bits.
- EXP_WIDTH, 8, exponent bits; element width W = SIG_WIDTH+EXP_WIDTH+1.
- IEEE_COMPLIANCE, 0, passed to core; 0 means no NaN/denormal support.
- NUM_LANES, 4, parallel dividers.
- IN_REG, 0, core input register stage count (0/1).
- STAGES, 6, core pipeline stages.
- OUT_REG, 1, core output register (0/1).
- TAG_W, 8, sideband tag width.
- FIFO_DEPTH, LATENCY+2, output FIFO entries; must be >= LATENCY+1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  transaction offered
- in_ready  out  1  transaction accepted when in_valid&in_ready at posedge
- in_op  in  1  0: z=a/b; 1: z=1.0/b (in_a ignored)
- in_tag  in  TAG_W  sideband, returned unchanged with result
- in_a  in  NUM_LANES*W  dividends, lane i at [i*W +: W]
- in_b  in  NUM_LANES*W  divisors
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid&out_ready at posedge
- out_z  out  NUM_LANES*W  quotients
- out_tag  out  TAG_W  tag of this result
- out_dz  out  NUM_LANES  per-lane divide-by-zero (only with VEC_DIV_STATUS_EN)

Behaviour:
- LATENCY = IN_REG + STAGES + OUT_REG - 1 (defaults: 6). Core is never stalled; enable tied high.
- Accept edge E0: operands, op-muxed dividend (1.0 = 0x3F800000 for default widths) and tag enter the pipe. A valid/tag shift register of LATENCY entries tracks the core.
- Edge E_LATENCY: result+tag are pushed into the FIFO. FIFO is first-word-fall-through with registered storage, so out_valid rises right after E_LATENCY when the FIFO was empty.
- Credit counter: occupancy = in-flight + FIFO count.
  - in_ready = (occupancy < FIFO_DEPTH) & ~rst.
  - Accept-only: +1. Pop-only: -1. Accept and pop on the same edge: unchanged.
  - The FIFO therefore can never overflow; no push is ever dropped.
- Throughput: 1 transaction/cycle sustained while out_ready=1.
- With out_ready=0, in_ready falls once occupancy reaches FIFO_DEPTH and rises the cycle after the first pop.
- FIFO wrap: read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; the count is tracked separately.
- Ordering: strictly in order. out_tag always pairs with its own out_z.
- Arithmetic per lane is the core result with round-to-nearest-even.
  - IEEE_COMPLIANCE=0: b=±0 gives ±inf; denormal inputs are treated as zero.
- out_z and out_tag are held stable while out_valid&~out_ready.
- Reset values: out_valid 0, out_z 0, out_tag 0, out_dz 0, in_ready 0 while rst=1, occupancy 0, pointers 0, valid shift register 0.
- Reset mid-operation: all in-flight and FIFO contents are discarded. No stale out_valid after deassertion. in_ready=1 the first cycle after rst falls.
- Core data registers need no reset.

Optional Feature:
- Macro VEC_DIV_STATUS_EN.
- Defined: per-lane divide-by-zero flag, computed at the accept edge (b exponent and mantissa all zero, and op either value), pipelined beside the tag and stored in the FIFO. Presented on out_dz, aligned with out_z.
- Undefined: the out_dz port, its pipeline bits and FIFO storage are absent.

Decomposition:
- Package vec_div_pkg holds:
  - typedefs: fp_t (W bits), lane_vec_t (NUM_LANES×fp_t), meta_t struct {tag, dz}.
  - constants: FP_ONE, LATENCY_CALC function.
- Sub-module fp_div_core: single-lane fixed-latency pipelined divider, instantiated NUM_LANES times via generate.
- FIFO and credit logic stay in the top module.

Test Plan:
- Single txn, lane0 a=0x40C00000 (6.0), b=0x40000000 (2.0), op=0, tag=0x5A → out_valid exactly after edge E6, out_z lane0=0x40400000, out_tag=0x5A.
- Reciprocal: op=1, b=0x40800000 (4.0), in_a=0xDEADBEEF → out_z=0x3E800000 (0.25).
- Back-to-back 100 random txns, out_ready=1 → in_ready never drops; results in order; rel. error ≤1e-5 vs a real-number model.
- Backpressure: out_ready=0, in_valid=1 continuously → exactly FIFO_DEPTH (8) accepts, then in_ready=0. Raise out_ready → in_ready=1 the next cycle; all 8 drain in order with no loss or duplication.
- b=0x00000000, a=0x3F800000 → out_z=0x7F800000; with VEC_DIV_STATUS_EN, out_dz[0]=1 and other lanes 0.
- Assert rst with 3 in flight and 2 queued → out_valid=0 during and after reset; the first post-reset transaction appears alone after 6 cycles.

Source files
------------

// File: rtl/vec_div_pkg.sv
// Shared types and constants for the vec_div_stream divider slice.
package vec_div_pkg;

  localparam int SIG_WIDTH_D = 23;
  localparam int EXP_WIDTH_D = 8;
  localparam int W_D         = SIG_WIDTH_D + EXP_WIDTH_D + 1;
  localparam int NUM_LANES_D = 4;
  localparam int TAG_W_D     = 8;

  typedef logic [W_D-1:0] fp_t;
  typedef fp_t [NUM_LANES_D-1:0] lane_vec_t;

  typedef struct packed {
    logic [TAG_W_D-1:0]     tag;
    logic [NUM_LANES_D-1:0] dz;
  } meta_t;

  function automatic int LATENCY_CALC(input int in_reg, input int stages, input int out_reg);
    return in_reg + stages + out_reg - 1;
  endfunction

  // 1.0 has a biased exponent of 0111..1 and an all-zero fraction.
  function automatic logic [63:0] fp_one(input int sig_w, input int exp_w);
    logic [63:0] v;
    v = '0;
    for (int i = sig_w; i < sig_w + exp_w - 1; i++) v[i] = 1'b1;
    return v;
  endfunction

  localparam fp_t FP_ONE = fp_t'(fp_one(SIG_WIDTH_D, EXP_WIDTH_D));

endpackage

// File: rtl/vec_div_stream_fp_div_core.sv
// Single-lane IEEE-754 divider, round-to-nearest-even, followed by a LAT-deep
// free-running register pipe (never stalled).
module fp_div_core #(
  parameter int SIG_WIDTH       = 23,
  parameter int EXP_WIDTH       = 8,
  parameter int IEEE_COMPLIANCE = 0,
  parameter int LAT             = 6
) (
  input  logic                         clk,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] i_a,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] i_b,
  output logic [SIG_WIDTH+EXP_WIDTH:0] o_z
);

  localparam int  W    = SIG_WIDTH + EXP_WIDTH + 1;
  localparam int  MW   = SIG_WIDTH + 1;
  localparam int  QW   = 2 * SIG_WIDTH + 3;
  localparam int  EW   = EXP_WIDTH + 2;
  localparam int  BIAS = 2 ** (EXP_WIDTH - 1) - 1;
  localparam int  EMAX = 2 ** EXP_WIDTH - 1;
  localparam bit  IEEE = (IEEE_COMPLIANCE != 0);

  logic                 w_sa, w_sb, w_sz;
  logic [EXP_WIDTH-1:0] w_ea, w_eb;
  logic [SIG_WIDTH-1:0] w_fa, w_fb;
  logic                 w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [QW-1:0]        w_num, w_den;
  logic [SIG_WIDTH+2:0] w_q;
  logic [MW-1:0]        w_rem;
  logic                 w_hi, w_rnd, w_stk, w_inc, w_ovf;
  logic [SIG_WIDTH-1:0] w_mant, w_frac;
  logic signed [EW-1:0] w_exp;
  logic [W-1:0]         w_res;

  assign {w_sa, w_ea, w_fa} = i_a;
  assign {w_sb, w_eb, w_fb} = i_b;
  assign w_sz = w_sa ^ w_sb;

  // Denormals flush to zero; without IEEE support an all-ones exponent is inf.
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) & (!IEEE || (w_fa == '0));
  assign w_b_inf  = (&w_eb) & (!IEEE || (w_fb == '0));
  assign w_a_nan  = IEEE && (&w_ea) && (w_fa != '0);
  assign w_b_nan  = IEEE && (&w_eb) && (w_fb != '0);

  // Quotient carries SIG_WIDTH+1 result bits plus a round bit; the rest is sticky.
  assign w_num = {1'b1, w_fa, {(SIG_WIDTH+2){1'b0}}};
  assign w_den = QW'({1'b1, w_fb});
  assign w_q   = (SIG_WIDTH+3)'(w_num / w_den);
  assign w_rem = MW'(w_num % w_den);

  always_comb begin
    w_hi   = w_q[SIG_WIDTH+2];
    w_mant = '0;
    w_rnd  = 1'b0;
    w_stk  = 1'b0;
    if (w_hi) begin
      w_mant = w_q[SIG_WIDTH+1:2];
      w_rnd  = w_q[1];
      w_stk  = w_q[0] | (|w_rem);
    end else begin
      w_mant = w_q[SIG_WIDTH:1];
      w_rnd  = w_q[0];
      w_stk  = |w_rem;
    end
    w_inc  = w_rnd & (w_stk | w_mant[0]);
    w_ovf  = w_inc & (&w_mant);
    w_frac = w_mant + SIG_WIDTH'(w_inc);
    w_exp  = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + EW'(BIAS)
             - EW'(w_hi ? 0 : 1) + EW'(w_ovf ? 1 : 0);

    if (w_exp >= EW'(EMAX))
      w_res = {w_sz, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
    else if (w_exp <= 0)
      w_res = {w_sz, {(W-1){1'b0}}};
    else
      w_res = {w_sz, w_exp[EXP_WIDTH-1:0], w_frac};

    if (w_a_nan || w_b_nan || (IEEE && ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf))))
      w_res = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};
    else if (w_b_zero || w_a_inf)
      w_res = {w_sz, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
    else if (w_a_zero || w_b_inf)
      w_res = {w_sz, {(W-1){1'b0}}};
  end

  logic [W-1:0] r_pipe [LAT];

  always_ff @(posedge clk) begin
    r_pipe[0] <= w_res;
    for (int k = 1; k < LAT; k++) r_pipe[k] <= r_pipe[k-1];
  end

  assign o_z = r_pipe[LAT-1];

endmodule

// File: rtl/vec_div_stream.sv
// Multi-lane streaming FP divider with credit-protected FWFT output FIFO.
// Optional per-lane divide-by-zero status under macro VEC_DIV_STATUS_EN.
module vec_div_stream
  import vec_div_pkg::*;
#(
  parameter int SIG_WIDTH       = 23,
  parameter int EXP_WIDTH       = 8,
  parameter int IEEE_COMPLIANCE = 0,
  parameter int NUM_LANES       = 4,
  parameter int IN_REG          = 0,
  parameter int STAGES          = 6,
  parameter int OUT_REG         = 1,
  parameter int TAG_W           = 8,
  parameter int FIFO_DEPTH      = LATENCY_CALC(IN_REG, STAGES, OUT_REG) + 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic                                          in_op,
  input  logic [TAG_W-1:0]                              in_tag,
  input  logic [NUM_LANES*(SIG_WIDTH+EXP_WIDTH+1)-1:0]  in_a,
  input  logic [NUM_LANES*(SIG_WIDTH+EXP_WIDTH+1)-1:0]  in_b,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [NUM_LANES*(SIG_WIDTH+EXP_WIDTH+1)-1:0]  out_z,
  output logic [TAG_W-1:0]                              out_tag
`ifdef VEC_DIV_STATUS_EN
  , output logic [NUM_LANES-1:0]                        out_dz
`endif
);

  localparam int          W       = SIG_WIDTH + EXP_WIDTH + 1;
  localparam int          LATENCY = LATENCY_CALC(IN_REG, STAGES, OUT_REG);
  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [63:0] ONE64   = fp_one(SIG_WIDTH, EXP_WIDTH);
  localparam logic [W-1:0] ONE    = ONE64[W-1:0];

  logic [NUM_LANES*W-1:0] w_z;
  logic                   w_accept, w_push, w_pop;
  logic [LATENCY-1:0]     r_vld;
  logic [TAG_W-1:0]       r_tag_pipe [LATENCY];
  logic [NUM_LANES*W-1:0] r_mem_z    [FIFO_DEPTH];
  logic [TAG_W-1:0]       r_mem_tag  [FIFO_DEPTH];
  logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]          r_count, r_occ;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [W-1:0] w_a_sel;
    assign w_a_sel = in_op ? ONE : in_a[gi*W +: W];
    fp_div_core #(
      .SIG_WIDTH       (SIG_WIDTH),
      .EXP_WIDTH       (EXP_WIDTH),
      .IEEE_COMPLIANCE (IEEE_COMPLIANCE),
      .LAT             (LATENCY)
    ) u_core (
      .clk (clk),
      .i_a (w_a_sel),
      .i_b (in_b[gi*W +: W]),
      .o_z (w_z[gi*W +: W])
    );
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Occupancy counts in-flight plus queued results, so a push always has room.
  assign in_ready  = (r_occ < CW'(FIFO_DEPTH)) & ~rst;
  assign w_accept  = in_valid & in_ready;
  assign w_push    = r_vld[LATENCY-1];
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  assign out_z     = out_valid ? r_mem_z[r_rd_ptr]   : '0;
  assign out_tag   = out_valid ? r_mem_tag[r_rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_occ    <= '0;
    end else begin
      r_vld[0] <= w_accept;
      for (int k = 1; k < LATENCY; k++) r_vld[k] <= r_vld[k-1];
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_tag_pipe[0] <= in_tag;
    for (int k = 1; k < LATENCY; k++) r_tag_pipe[k] <= r_tag_pipe[k-1];
    if (w_push) begin
      r_mem_z[r_wr_ptr]   <= w_z;
      r_mem_tag[r_wr_ptr] <= r_tag_pipe[LATENCY-1];
    end
  end

`ifdef VEC_DIV_STATUS_EN
  logic [NUM_LANES-1:0] w_dz_in;
  logic [NUM_LANES-1:0] r_dz_pipe [LATENCY];
  logic [NUM_LANES-1:0] r_mem_dz  [FIFO_DEPTH];

  // Zero divisor: exponent and mantissa clear, sign ignored.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_dz
    assign w_dz_in[gi] = (in_b[gi*W +: W-1] == '0);
  end

  always_ff @(posedge clk) begin
    r_dz_pipe[0] <= w_dz_in;
    for (int k = 1; k < LATENCY; k++) r_dz_pipe[k] <= r_dz_pipe[k-1];
    if (w_push) r_mem_dz[r_wr_ptr] <= r_dz_pipe[LATENCY-1];
  end

  assign out_dz = out_valid ? r_mem_dz[r_rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_vec_div_stream.sv
// Directed self-checking bench for vec_div_stream (default parameters).
module tb_vec_div_stream;
  import vec_div_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_op;
  logic [7:0]   in_tag;
  logic [127:0] in_a, in_b;
  logic         out_valid, out_ready;
  logic [127:0] out_z;
  logic [7:0]   out_tag;
`ifdef VEC_DIV_STATUS_EN
  logic [3:0]   out_dz;
`endif

  always #5 clk = ~clk;

  vec_div_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_tag   (out_tag)
`ifdef VEC_DIV_STATUS_EN
    , .out_dz  (out_dz)
`endif
  );

  typedef struct packed {
    logic [7:0] tag;
    logic       op;
    lane_vec_t  a;
    lane_vec_t  b;
  } sb_t;

  sb_t sb[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  n_rx     = 0;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic real f2r(input fp_t x);
    real m;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic fp_t rnd_fp();
    return {1'($urandom), 8'($urandom_range(144, 110)), 23'($urandom)};
  endfunction

  function automatic lane_vec_t rnd_vec();
    lane_vec_t v;
    for (int i = 0; i < 4; i++) v[i] = rnd_fp();
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records the handshakes the next edge will perform, checks any popped result.
  task automatic step();
    sb_t e;
    real q, r, err;
    if (in_valid && in_ready) begin
      e.tag = in_tag; e.op = in_op; e.a = in_a; e.b = in_b;
      sb.push_back(e);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {120'd0, out_tag}, 128'd0 - 1);
      end else begin
        e = sb.pop_front();
        n_rx++;
        chk("stream_tag", {120'd0, out_tag}, {120'd0, e.tag});
        for (int i = 0; i < 4; i++) begin
          q   = (e.op ? 1.0 : f2r(e.a[i])) / f2r(e.b[i]);
          r   = f2r(out_z[i*32 +: 32]);
          err = (r - q) / q;
          if (err < 0.0) err = -err;
          chk("stream_relerr", {127'd0, err <= 1.0e-5}, 128'd1);
        end
      end
    end
    tick();
  endtask

  task automatic run_single(input string name, input logic op, input logic [7:0] tag,
                            input lane_vec_t a, input lane_vec_t b,
                            input lane_vec_t exp_z, input logic [3:0] exp_dz);
    int k;
    in_valid = 1'b1; in_op = op; in_tag = tag; in_a = a; in_b = b;
    out_ready = 1'b0;
    chk({name, "_in_ready"}, {127'd0, in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0;
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    chk({name, "_latency"}, 128'(k), 128'd6);
    chk({name, "_z"}, out_z, exp_z);
    chk({name, "_tag"}, {120'd0, out_tag}, {120'd0, tag});
`ifdef VEC_DIV_STATUS_EN
    chk({name, "_dz"}, {124'd0, out_dz}, {124'd0, exp_dz});
`else
    if (exp_dz != exp_dz) chk({name, "_dz"}, 128'd0, 128'd1);
`endif
    tick();
    chk({name, "_hold_z"}, out_z, exp_z);
    chk({name, "_hold_valid"}, {127'd0, out_valid}, 128'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_popped"}, {127'd0, out_valid}, 128'd0);
  endtask

  initial begin : main
    lane_vec_t a, b, z;
    int        accepts, k;
    logic      seen;

    rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_tag = '0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_z", out_z, 128'd0);
    chk("rst_out_tag", {120'd0, out_tag}, 128'd0);
`ifdef VEC_DIV_STATUS_EN
    chk("rst_out_dz", {124'd0, out_dz}, 128'd0);
`endif
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);
    tick();

    // a/b with exact and rounded (1/3) lanes
    a = {32'h3F800000, 32'hC0400000, 32'h3F800000, 32'h40C00000};
    b = {32'h40400000, 32'h3FC00000, 32'h40000000, 32'h40000000};
    z = {32'h3EAAAAAB, 32'hC0000000, 32'h3F000000, 32'h40400000};
    run_single("div", 1'b0, 8'h5A, a, b, z, 4'b0000);

    // reciprocal, in_a is garbage
    a = {4{32'hDEADBEEF}};
    b = {32'h41200000, 32'hC1000000, 32'h3F000000, 32'h40800000};
    z = {32'h3DCCCCCD, 32'hBE000000, 32'h40000000, 32'h3E800000};
    run_single("recip", 1'b1, 8'h3C, a, b, z, 4'b0000);

    // divide by zero, zero dividend, exponent overflow
    a = {32'h7F000000, 32'h00000000, 32'hC0000000, 32'h3F800000};
    b = {32'h3F000000, 32'h40000000, 32'h3F800000, 32'h00000000};
    z = {32'h7F800000, 32'h00000000, 32'hC0000000, 32'h7F800000};
    run_single("divzero", 1'b0, 8'hE1, a, b, z, 4'b0001);

    // 100 back-to-back transactions with the sink always ready
    n_rx = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      in_valid = 1'b1; in_op = 1'($urandom); in_tag = 8'(t);
      in_a = rnd_vec(); in_b = rnd_vec();
      chk("stream_in_ready", {127'd0, in_ready}, 128'd1);
      step();
    end
    in_valid = 1'b0;
    k = 0;
    while (sb.size() > 0 && k < 40) begin step(); k++; end
    chk("stream_count", 128'(n_rx), 128'd100);
    chk("stream_sb_empty", 128'(sb.size()), 128'd0);

    // backpressure: sink stalled, source always offering
    n_rx = 0; accepts = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 15; c++) begin
      in_valid = 1'b1; in_op = 1'b0; in_tag = 8'(8'h80 + c);
      in_a = rnd_vec(); in_b = rnd_vec();
      if (in_ready) accepts++;
      step();
    end
    chk("bp_accepts", 128'(accepts), 128'd8);
    chk("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
    chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
    out_ready = 1'b1;
    step();
    chk("bp_in_ready_after_pop", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b0;
    k = 0;
    while (sb.size() > 0 && k < 40) begin step(); k++; end
    chk("bp_drain_count", 128'(n_rx), 128'd8);
    chk("bp_drain_empty", {127'd0, out_valid}, 128'd0);

    // reset with 3 in flight and 2 queued
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      in_valid = 1'b1; in_op = 1'b0; in_tag = 8'(8'h40 + t);
      in_a = rnd_vec(); in_b = rnd_vec();
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("pre_rst_out_valid", {127'd0, out_valid}, 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd0);
    tick();
    tick();
    chk("held_rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("held_rst_out_tag", {120'd0, out_tag}, 128'd0);
    rst = 1'b0;
    sb.delete();
    #1;
    chk("rel_rst_in_ready", {127'd0, in_ready}, 128'd1);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("no_stale_valid", {127'd0, seen}, 128'd0);
    a = {32'h3F800000, 32'hC0400000, 32'h3F800000, 32'h40C00000};
    b = {32'h40400000, 32'h3FC00000, 32'h40000000, 32'h40000000};
    z = {32'h3EAAAAAB, 32'hC0000000, 32'h3F000000, 32'h40400000};
    run_single("post_rst", 1'b0, 8'hC3, a, b, z, 4'b0000);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("post_rst_alone", {127'd0, seen}, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
